// File: rtl/chroni_pkg.sv
// Shared line-buffer definitions: writer FSM encodings, default line width, buffer address width.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package chroni_pkg;

   localparam int LINE_WIDTH_DEFAULT = 640;
   localparam int BUF_ADDR_W         = 11;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_FILL = 2'd2;
   localparam logic [1:0] ST_WAIT = 2'd3;

   // Last phase value before the read bank flips: 2 or 4 scanlines per rendered line.
   function automatic logic [1:0] phase_max(input logic pixel_scale);
      return pixel_scale ? 2'd3 : 2'd1;
   endfunction

endpackage

// File: rtl/line_phase_counter.sv
// Counts VGA scanlines inside a rendered line and flips the read bank when the line period ends.
// Latency: read_bank updates 1 cycle after the scanline_start that ends the period; toggle is combinational.
// Backpressure: none; free-running once started, halted by stop.
// Ports: clk/reset_n; start (render_start), stop (mode_changed, wins over start);
//        scanline_start, pixel_scale in; read_bank out, toggle = pulse in the cycle the bank flips.
module line_phase_counter
   import chroni_pkg::*;
(
   input  logic clk,
   input  logic reset_n,
   input  logic start,
   input  logic stop,
   input  logic scanline_start,
   input  logic pixel_scale,
   output logic read_bank,
   output logic toggle
);

   logic       active;
   logic [1:0] phase;

   // >= rather than == so a pixel_scale change mid-line cannot strand phase above the limit.
   assign toggle = active && scanline_start && !start && !stop &&
                   (phase >= phase_max(pixel_scale));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         active    <= 1'b0;
         phase     <= 2'd0;
         read_bank <= 1'b0;
      end else if (stop) begin
         active    <= 1'b0;
         phase     <= 2'd0;
         read_bank <= 1'b0;
      end else if (start) begin
         // A scanline_start in the same cycle is swallowed: phase stays 0.
         active    <= 1'b1;
         phase     <= 2'd0;
         read_bank <= 1'b0;
      end else if (active && scanline_start) begin
         if (toggle) begin
            phase     <= 2'd0;
            read_bank <= ~read_bank;
         end else begin
            phase <= phase + 2'd1;
         end
      end
   end

endmodule

// File: rtl/line_buffer_writer.sv
// Fills a two-bank line buffer with rendered pixels, one line ahead of the bank being displayed.
// Latency: buffer write appears 1 cycle after each pix_valid/pix_ready transfer.
// Backpressure: pix_ready is high only while filling; upstream holds pix_data until accepted.
// Ports: sys_clk/reset_n; video timing pulses (mode_changed, frame_start, render_start, scanline_start);
//        pixel_scale, vis_lines config; line_req/line_num request; pix_valid/pix_data/pix_ready stream;
//        buf_we/buf_addr/buf_data buffer write; blank_scanline, underrun status.
module line_buffer_writer
   import chroni_pkg::*;
#(
   parameter int LINE_WIDTH = LINE_WIDTH_DEFAULT,
   parameter int LINE_BITS  = 10
) (
   input  logic                  sys_clk,
   input  logic                  reset_n,
   input  logic                  mode_changed,
   input  logic                  frame_start,
   input  logic                  render_start,
   input  logic                  scanline_start,
   input  logic                  pixel_scale,
   input  logic [LINE_BITS-1:0]  vis_lines,
   output logic                  line_req,
   output logic [LINE_BITS-1:0]  line_num,
   input  logic                  pix_valid,
   input  logic [15:0]           pix_data,
   output logic                  pix_ready,
   output logic                  buf_we,
   output logic [BUF_ADDR_W-1:0] buf_addr,
   output logic [15:0]           buf_data,
   output logic                  blank_scanline,
   output logic                  underrun
);

   localparam logic [LINE_BITS-1:0]  ONE     = LINE_BITS'(1);
   localparam logic [LINE_BITS-1:0]  LAST_X  = LINE_BITS'(LINE_WIDTH - 1);
   localparam logic [BUF_ADDR_W-1:0] BANK1_A = BUF_ADDR_W'(LINE_WIDTH);

   logic [1:0]           state;
   logic                 fill_bank;
   logic                 read_bank;
   logic                 new_read;
   logic                 toggle;
   logic                 blank;
   logic [LINE_BITS-1:0] x;
   logic [LINE_BITS-1:0] vis_lat;
   logic [LINE_BITS-1:0] next_line;
   logic [1:0]           complete;
   logic [1:0]           done_mask;
   logic [1:0]           complete_now;
   logic                 start;
   logic                 xfer;
   logic                 fill_done;
   logic                 more_lines;
   logic                 do_toggle;

   line_phase_counter u_phase (
      .clk            (sys_clk),
      .reset_n        (reset_n),
      .start          (render_start),
      .stop           (mode_changed),
      .scanline_start (scanline_start),
      .pixel_scale    (pixel_scale),
      .read_bank      (read_bank),
      .toggle         (toggle)
   );

   // mode_changed cuts the handshake in its own cycle so no write follows it.
   assign start          = render_start && !mode_changed;
   assign pix_ready      = (state == ST_FILL) && !mode_changed;
   assign line_req       = (state == ST_REQ) && !mode_changed;
   assign blank_scanline = blank;

   assign xfer       = pix_valid && pix_ready;
   assign fill_done  = xfer && (x == LAST_X);
   assign next_line  = line_num + ONE;
   assign more_lines = next_line < vis_lat;
   assign do_toggle  = toggle && (state != ST_IDLE);
   assign new_read   = ~read_bank;

   // Completion status including a line that finishes on this very edge.
   assign done_mask    = fill_done ? (fill_bank ? 2'b10 : 2'b01) : 2'b00;
   assign complete_now = complete | done_mask;

   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         fill_bank <= 1'b0;
         x         <= '0;
         vis_lat   <= '0;
         line_num  <= '0;
         complete  <= 2'b00;
         buf_we    <= 1'b0;
         buf_addr  <= '0;
         buf_data  <= '0;
         blank     <= 1'b1;
         underrun  <= 1'b0;
      end else begin
         buf_we <= xfer;
         if (xfer) begin
            buf_addr <= fill_bank ? (BANK1_A + BUF_ADDR_W'(x)) : BUF_ADDR_W'(x);
            buf_data <= pix_data;
            x        <= fill_done ? '0 : (x + ONE);
         end
         complete <= complete_now;
         if (frame_start) underrun <= 1'b0;

         if (mode_changed) begin
            state <= ST_IDLE;
            blank <= 1'b1;
            x     <= '0;
         end else if (start) begin
            state     <= ST_REQ;
            line_num  <= '0;
            fill_bank <= 1'b0;
            vis_lat   <= vis_lines;
            x         <= '0;
            complete  <= 2'b00;
         end else if (do_toggle) begin
            // Underrun setting overrides a frame_start clear in the same cycle.
            blank <= !complete_now[new_read];
            if (!complete_now[new_read]) underrun <= 1'b1;
            if (more_lines) begin
               // Released bank gets the next line; any fill in flight is abandoned.
               state               <= ST_REQ;
               fill_bank           <= read_bank;
               line_num            <= next_line;
               x                   <= '0;
               complete[read_bank] <= 1'b0;
            end else if (fill_done) begin
               state <= ST_IDLE;
            end
         end else begin
            case (state)
               ST_REQ: state <= ST_FILL;
               ST_FILL: begin
                  if (fill_done) begin
                     if (fill_bank == read_bank) blank <= 1'b0;
                     if (!more_lines) begin
                        state <= ST_IDLE;
                     end else if (line_num == '0) begin
                        // Line 1 goes straight into bank 1 so both banks are primed.
                        state     <= ST_REQ;
                        fill_bank <= 1'b1;
                        line_num  <= next_line;
                     end else begin
                        state <= ST_WAIT;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_line_buffer_writer.sv
module tb_line_buffer_writer;

   typedef struct packed {
      logic        lreq;
      logic [9:0]  lnum;
      logic        prdy;
      logic        we;
      logic [10:0] addr;
      logic [15:0] data;
      logic        blank;
      logic        und;
   } out_t;

   typedef struct packed {
      logic        rst;
      logic        mc;
      logic        fs;
      logic        rs;
      logic        ss;
      logic        pv;
      logic [15:0] pd;
      out_t        exp_o;
   } vec_t;

   logic        sys_clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        mode_changed = 1'b0;
   logic        frame_start = 1'b0;
   logic        render_start = 1'b0;
   logic        scanline_start = 1'b0;
   logic        pixel_scale = 1'b0;
   logic [9:0]  vis_lines = 10'd5;
   logic        line_req;
   logic [9:0]  line_num;
   logic        pix_valid = 1'b0;
   logic [15:0] pix_data = 16'h0;
   logic        pix_ready;
   logic        buf_we;
   logic [10:0] buf_addr;
   logic [15:0] buf_data;
   logic        blank_scanline;
   logic        underrun;

   int n_pass  = 0;
   int n_total = 0;

   always #5 sys_clk = ~sys_clk;

   line_buffer_writer dut (
      .sys_clk        (sys_clk),
      .reset_n        (reset_n),
      .mode_changed   (mode_changed),
      .frame_start    (frame_start),
      .render_start   (render_start),
      .scanline_start (scanline_start),
      .pixel_scale    (pixel_scale),
      .vis_lines      (vis_lines),
      .line_req       (line_req),
      .line_num       (line_num),
      .pix_valid      (pix_valid),
      .pix_data       (pix_data),
      .pix_ready      (pix_ready),
      .buf_we         (buf_we),
      .buf_addr       (buf_addr),
      .buf_data       (buf_data),
      .blank_scanline (blank_scanline),
      .underrun       (underrun)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
      n_total++;
      if (act === exp_v) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp_v);
   endtask

   // One clock: inputs set beforehand are captured, then pulses drop and outputs settle.
   task automatic tick();
      @(posedge sys_clk);
      #1;
      mode_changed   = 1'b0;
      frame_start    = 1'b0;
      render_start   = 1'b0;
      scanline_start = 1'b0;
   endtask

   function automatic vec_t mk(input logic rst, mc, fs, rs, ss, pv, input logic [15:0] pd,
                               input logic lreq, input logic [9:0] lnum, input logic prdy, we,
                               input logic [10:0] addr, input logic [15:0] data,
                               input logic blank, und);
      vec_t v;
      v.rst = rst; v.mc = mc; v.fs = fs; v.rs = rs; v.ss = ss; v.pv = pv; v.pd = pd;
      v.exp_o.lreq = lreq; v.exp_o.lnum = lnum; v.exp_o.prdy = prdy; v.exp_o.we = we;
      v.exp_o.addr = addr; v.exp_o.data = data; v.exp_o.blank = blank; v.exp_o.und = und;
      return v;
   endfunction

   function automatic out_t cur();
      out_t o;
      o.lreq = line_req; o.lnum = line_num; o.prdy = pix_ready; o.we = buf_we;
      o.addr = buf_addr; o.data = buf_data; o.blank = blank_scanline; o.und = underrun;
      return o;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t tbl[18];
      int   cnt, nwr, errs, req1;
      logic [15:0] d;

      // rst mc fs rs ss pv pd      | lreq lnum prdy we addr data   blank und
      tbl[0]  = mk(0,0,0,0,0,0,16'h0,    0,0,0,0,0,16'h0,    1,0);
      tbl[1]  = mk(1,0,0,0,0,0,16'h0,    0,0,0,0,0,16'h0,    1,0);
      tbl[2]  = mk(1,0,0,0,1,0,16'h0,    0,0,0,0,0,16'h0,    1,0);
      tbl[3]  = mk(1,0,0,1,0,0,16'h0,    1,0,0,0,0,16'h0,    1,0);
      tbl[4]  = mk(1,0,0,0,0,0,16'h0,    0,0,1,0,0,16'h0,    1,0);
      tbl[5]  = mk(1,0,0,0,0,1,16'hA5A5, 0,0,1,1,0,16'hA5A5, 1,0);
      tbl[6]  = mk(1,0,0,0,0,1,16'h1234, 0,0,1,1,1,16'h1234, 1,0);
      tbl[7]  = mk(1,0,0,0,0,0,16'h0,    0,0,1,0,1,16'h1234, 1,0);
      tbl[8]  = mk(1,0,0,0,1,0,16'h0,    0,0,1,0,1,16'h1234, 1,0);
      tbl[9]  = mk(1,0,0,0,1,0,16'h0,    1,1,0,0,1,16'h1234, 1,1);
      tbl[10] = mk(1,0,1,0,0,0,16'h0,    0,1,1,0,1,16'h1234, 1,0);
      tbl[11] = mk(1,1,0,0,0,0,16'h0,    0,1,0,0,1,16'h1234, 1,0);
      tbl[12] = mk(1,0,0,0,1,0,16'h0,    0,1,0,0,1,16'h1234, 1,0);
      tbl[13] = mk(1,1,0,1,0,0,16'h0,    0,1,0,0,1,16'h1234, 1,0);
      tbl[14] = mk(1,0,0,1,1,0,16'h0,    1,0,0,0,1,16'h1234, 1,0);
      tbl[15] = mk(1,0,0,0,0,0,16'h0,    0,0,1,0,1,16'h1234, 1,0);
      tbl[16] = mk(1,0,0,0,1,0,16'h0,    0,0,1,0,1,16'h1234, 1,0);
      tbl[17] = mk(1,0,0,0,1,0,16'h0,    1,1,0,0,1,16'h1234, 1,1);

      #2;
      pixel_scale = 1'b0;
      vis_lines   = 10'd5;
      for (int i = 0; i < 18; i++) begin
         reset_n        = tbl[i].rst;
         mode_changed   = tbl[i].mc;
         frame_start    = tbl[i].fs;
         render_start   = tbl[i].rs;
         scanline_start = tbl[i].ss;
         pix_valid      = tbl[i].pv;
         pix_data       = tbl[i].pd;
         tick();
         check($sformatf("vec%0d", i), 64'(cur()), 64'(tbl[i].exp_o));
      end

      // Reset release alone never requests a line, even with scanlines running.
      pix_valid = 1'b0;
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         scanline_start = i[0];
         tick();
         if (line_req) cnt++;
      end
      check("no_req_after_reset", 64'(cnt), 64'd0);

      // Two lines back to back, then line 2 after four scanlines, then idle.
      vis_lines    = 10'd3;
      pixel_scale  = 1'b1;
      pix_valid    = 1'b1;
      render_start = 1'b1;
      tick();
      check("A_req0", 64'({line_req, line_num}), 64'({1'b1, 10'd0}));
      nwr = 0; errs = 0; req1 = -1;
      for (int c = 0; c < 3000 && nwr < 1280; c++) begin
         d = 16'(c * 3 + 1);
         pix_data = d;
         tick();
         if (buf_we) begin
            if (buf_addr != 11'(nwr) || buf_data != d) errs++;
            nwr++;
         end
         if (line_req && line_num == 10'd1 && req1 < 0) req1 = nwr;
      end
      check("A_writes", 64'(nwr), 64'd1280);
      check("A_write_errs", 64'(errs), 64'd0);
      check("A_req1_after_line0", 64'(req1), 64'd640);
      tick();
      check("A_wait", 64'({pix_ready, line_req, buf_we}), 64'd0);
      cnt = 0;
      for (int k = 0; k < 3; k++) begin
         scanline_start = 1'b1;
         tick();
         if (line_req) cnt++;
         tick();
         if (line_req) cnt++;
      end
      check("A_no_req_3ss", 64'(cnt), 64'd0);
      scanline_start = 1'b1;
      tick();
      check("A_req2", 64'({line_req, line_num, blank_scanline, underrun}),
            64'({1'b1, 10'd2, 1'b0, 1'b0}));
      nwr = 0; errs = 0;
      for (int c = 0; c < 2000 && nwr < 640; c++) begin
         d = 16'(c * 5 + 7);
         pix_data = d;
         tick();
         if (buf_we) begin
            if (buf_addr != 11'(nwr) || buf_data != d) errs++;
            nwr++;
         end
      end
      check("A_line2_writes", 64'(nwr), 64'd640);
      check("A_line2_errs", 64'(errs), 64'd0);
      tick();
      check("A_idle", 64'({pix_ready, line_req}), 64'd0);
      cnt = 0;
      for (int k = 0; k < 8; k++) begin
         scanline_start = 1'b1;
         tick();
         if (line_req || pix_ready) cnt++;
      end
      check("A_idle_ignores_ss", 64'(cnt), 64'd0);

      // mode_changed in the middle of a fill, then a clean restart.
      pixel_scale  = 1'b0;
      vis_lines    = 10'd5;
      render_start = 1'b1;
      tick();
      nwr = 0;
      for (int c = 0; c < 1000 && nwr < 300; c++) begin
         pix_data = 16'(c);
         tick();
         if (buf_we) nwr++;
      end
      check("C_writes_before_mc", 64'(nwr), 64'd300);
      mode_changed = 1'b1;
      tick();
      check("C_mc", 64'({buf_we, pix_ready, line_req, blank_scanline}), 64'(4'b0001));
      tick();
      check("C_idle", 64'({buf_we, pix_ready, line_req}), 64'd0);
      render_start = 1'b1;
      tick();
      check("C_req0", 64'({line_req, line_num}), 64'({1'b1, 10'd0}));
      for (int c = 0; c < 10 && !buf_we; c++) tick();
      check("C_first_addr", 64'(buf_we ? buf_addr : 11'h7ff), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/line_buffer_writer.md
LINE_BUFFER_WRITER -- requirements
Module: line_buffer_writer

Interface
REQ-001 Parameter LINE_WIDTH, default 640: pixels per rendered line; also the base address of bank 1.
REQ-002 Parameter LINE_BITS, default 10: width of the line number and pixel x counters.
REQ-003 sys_clk  in  1  sole clock; all logic is on the rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 mode_changed  in  1  one-cycle pulse: the video mode was reloaded.
REQ-006 frame_start  in  1  one-cycle pulse at the start of each frame.
REQ-007 render_start  in  1  one-cycle pulse, one scanline before the playfield starts.
REQ-008 scanline_start  in  1  one-cycle pulse at the end of each VGA scanline.
REQ-009 pixel_scale  in  1  line display period: 0 = 2 scanlines per rendered line, 1 = 4.
REQ-010 vis_lines  in  LINE_BITS  number of rendered lines per frame; sampled at render_start.
REQ-011 line_req  out  1  one-cycle pulse requesting pixel data for line_num.
REQ-012 line_num  out  LINE_BITS  line being requested or filled.
REQ-013 pix_valid  in  1  pix_data is valid.
REQ-014 pix_data  in  16  pixel in RGB565 format.
REQ-015 pix_ready  out  1  the writer accepts pix_data this cycle.
REQ-016 buf_we  out  1  line buffer write strobe.
REQ-017 buf_addr  out  11  line buffer write address.
REQ-018 buf_data  out  16  line buffer write data.
REQ-019 blank_scanline  out  1  the line now being read is incomplete.
REQ-020 underrun  out  1  sticky flag, cleared at frame_start.

Function
REQ-021 FSM states: IDLE, REQ, FILL, WAIT.
- REQ issues line_req, then goes to FILL.
- FILL ends after LINE_WIDTH writes, then goes to WAIT or REQ.
REQ-022 A pixel is transferred in a cycle where both pix_valid and pix_ready are 1.
REQ-023 Each transfer drives buf_we=1, buf_addr = bank*LINE_WIDTH + x, buf_data = pix_data, all registered, so the write appears 1 cycle after the transfer.
REQ-024 x increments on each transfer and returns to 0 after LINE_WIDTH-1.
REQ-025 pix_ready=1 only in FILL.
REQ-026 On render_start:
- read_bank=0, line_num=0, phase=0, fill bank=0, vis_lines latched;
- FSM enters REQ from any state, aborting any fill in progress.
REQ-027 After line 0 completes in bank 0, line 1 is filled into bank 1 immediately, with no wait.
REQ-028 Phase counting:
- phase increments on each scanline_start after render_start;
- at phase = 1 (pixel_scale=0) or 3 (pixel_scale=1), phase returns to 0 and read_bank toggles.
REQ-029 On each read_bank toggle, the released bank is refilled with the next line, line_num+1, if it is below vis_lines; otherwise the FSM stays in WAIT.
REQ-030 At a toggle, if the bank becoming read is not fully written, blank_scanline=1 until that bank completes, and underrun is set.
REQ-031 A toggle that arrives while a fill is still in progress aborts that fill and starts the new one; the aborted bank is marked incomplete.
REQ-032 After line vis_lines-1 completes, the FSM enters IDLE and ignores scanline_start until the next render_start.
REQ-033 mode_changed forces IDLE and blank_scanline=1, and deasserts line_req, pix_ready and buf_we; it has priority over render_start in the same cycle.
REQ-034 If frame_start and a transfer occur in the same cycle, the transfer is completed and underrun is cleared.
REQ-035 Simultaneous render_start and scanline_start: render_start wins, and phase stays 0.
REQ-036 Width rules:
- LINE_BITS counters wrap modulo 2^LINE_BITS;
- buf_addr is 11 bits and is never above 2*LINE_WIDTH-1.

Reset
REQ-037 While reset_n=0, the following are held at 0: state=IDLE, line_req, pix_ready, buf_we, buf_addr, buf_data, line_num, underrun, phase, read_bank, and the bank-complete flags.
REQ-038 While reset_n=0, blank_scanline is held at 1.
REQ-039 Reset deassertion does not start a fill; the first fill begins at render_start.

Structure
REQ-040 State encodings and the LINE_WIDTH default are placed in the shared chroni package/header.
REQ-041 The block uses one sub-module, line_phase_counter, for the scanline phase and read_bank tracking.

Verification
REQ-042 Reset: reset_n=0 -> blank_scanline=1 and all other outputs 0; after release with no render_start -> no line_req ever.
REQ-043 render_start with pix_valid held 1 -> line_req for line 0, writes to addresses 0..639, then line_req for line 1 with writes to 640..1279.
REQ-044 pixel_scale=1, vis_lines=3 -> line 2 is written into bank 0 after the 4th scanline_start, then the FSM goes IDLE.
REQ-045 pix_valid stuck at 0, then scanline_start toggles the read bank -> blank_scanline=1 and underrun=1; the next frame_start -> underrun=0.
REQ-046 mode_changed in the middle of a fill (x=300) -> buf_we=0 on the next cycle, then IDLE; the following render_start restarts at x=0 in bank 0.
